// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the TSC CPU instruction fetch stage: the datapath
// width and the fetch FSM state encoding. Both the fetch stage and its
// next-PC calculator import this package so neither redefines them locally.
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

   // Datapath / address width of the 16-bit TSC CPU.
   localparam int IF_WORD_SIZE = 16;

   // Fetch FSM states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_HOLD   = 3'd3,
      ST_HALTED = 3'd4
   } if_state_e;

endpackage : instruction_fetch_pkg

// File: rtl/instruction_fetch_next_pc_calc.sv
// -----------------------------------------------------------------------------
// next_pc_calc
// Purely combinational next-PC selection for the fetch stage.
// Priority: register jump > J-type jump > taken branch > sequential.
// All arithmetic wraps modulo 2^WORD_SIZE.
//
// Ports:
//   pc           in   current instruction address
//   inst         in   current instruction word (jump field / branch offset)
//   jump_en      in   J-type jump: {pc[top 4 bits], inst[low bits]}
//   jpr_en       in   register jump: reg_target
//   branch_taken in   branch: pc + 1 + sign-extended inst[7:0]
//   reg_target   in   register jump target
//   next_pc      out  selected next PC
// -----------------------------------------------------------------------------
module next_pc_calc
   import instruction_fetch_pkg::*;
#(
   parameter int WORD_SIZE = IF_WORD_SIZE
) (
   input  logic [WORD_SIZE-1:0] pc,
   input  logic [WORD_SIZE-1:0] inst,
   input  logic                 jump_en,
   input  logic                 jpr_en,
   input  logic                 branch_taken,
   input  logic [WORD_SIZE-1:0] reg_target,
   output logic [WORD_SIZE-1:0] next_pc
);

   logic [WORD_SIZE-1:0] seq_pc;
   logic [WORD_SIZE-1:0] branch_off;

   assign seq_pc     = pc + WORD_SIZE'(1);
   // Branch offset is the signed low byte of the instruction.
   assign branch_off = {{(WORD_SIZE-8){inst[7]}}, inst[7:0]};

   always_comb begin
      next_pc = seq_pc;
      if (jpr_en) begin
         next_pc = reg_target;
      end else if (jump_en) begin
         // J-type target keeps the current 4-bit page of the PC.
         next_pc = {pc[WORD_SIZE-1 -: 4], inst[WORD_SIZE-5:0]};
      end else if (branch_taken) begin
         next_pc = seq_pc + branch_off;
      end
   end

endmodule : next_pc_calc

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Multi-cycle fetch stage for the 16-bit TSC CPU. Owns the PC, fetches one
// word through the readM/inputReady handshake, holds it on inst until commit,
// then loads the next PC (from next_pc_calc) and starts the next fetch.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   address, readM      memory request (address always shows pc)
//   data, inputReady    memory response, data valid when inputReady=1
//   inst, inst_valid    fetched word and "uncommitted instruction held" flag
//   pc, pc_plus1        address of inst and its link value pc+1
//   commit              one-cycle pulse: current instruction finished
//   jump_en, jpr_en,
//   branch_taken,
//   reg_target          next-PC controls, sampled only with commit in HOLD
//   halt                sampled with commit; stops fetching until reset
// -----------------------------------------------------------------------------
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int                   WORD_SIZE = IF_WORD_SIZE,
   parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   output logic [WORD_SIZE-1:0] address,
   output logic                 readM,
   input  logic [WORD_SIZE-1:0] data,
   input  logic                 inputReady,
   output logic [WORD_SIZE-1:0] inst,
   output logic                 inst_valid,
   output logic [WORD_SIZE-1:0] pc,
   output logic [WORD_SIZE-1:0] pc_plus1,
   input  logic                 commit,
   input  logic                 jump_en,
   input  logic                 jpr_en,
   input  logic [WORD_SIZE-1:0] reg_target,
   input  logic                 branch_taken,
   input  logic                 halt
);

   if_state_e            state_q;
   logic [WORD_SIZE-1:0] pc_q;
   logic [WORD_SIZE-1:0] inst_q;
   logic                 inst_valid_q;
   logic                 readm_q;
   logic [WORD_SIZE-1:0] next_pc_d;

   next_pc_calc #(
      .WORD_SIZE (WORD_SIZE)
   ) u_next_pc_calc (
      .pc           (pc_q),
      .inst         (inst_q),
      .jump_en      (jump_en),
      .jpr_en       (jpr_en),
      .branch_taken (branch_taken),
      .reg_target   (reg_target),
      .next_pc      (next_pc_d)
   );

   // readM is registered: it is set on the edge entering FETCH and cleared
   // on the capture edge, so it is high exactly during FETCH and WAIT.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         inst_q       <= '0;
         inst_valid_q <= 1'b0;
         readm_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_q <= ST_FETCH;
               readm_q <= 1'b1;
            end
            ST_FETCH: begin
               state_q <= ST_WAIT;
               readm_q <= 1'b1;
            end
            ST_WAIT: begin
               if (inputReady) begin
                  inst_q       <= data;
                  inst_valid_q <= 1'b1;
                  readm_q      <= 1'b0;
                  state_q      <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (commit) begin
                  // PC advances even when halting so it reflects the
                  // instruction after the halting one.
                  pc_q         <= next_pc_d;
                  inst_valid_q <= 1'b0;
                  if (halt) begin
                     state_q <= ST_HALTED;
                     readm_q <= 1'b0;
                  end else begin
                     state_q <= ST_FETCH;
                     readm_q <= 1'b1;
                  end
               end
            end
            ST_HALTED: begin
               readm_q      <= 1'b0;
               inst_valid_q <= 1'b0;
            end
            default: begin
               state_q      <= ST_IDLE;
               readm_q      <= 1'b0;
               inst_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign address    = pc_q;
   assign readM      = readm_q;
   assign inst       = inst_q;
   assign inst_valid = inst_valid_q;
   assign pc         = pc_q;
   assign pc_plus1   = pc_q + WORD_SIZE'(1);

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] address;
   logic        readM;
   logic [15:0] data;
   logic        inputReady;
   logic [15:0] inst;
   logic        inst_valid;
   logic [15:0] pc;
   logic [15:0] pc_plus1;
   logic        commit;
   logic        jump_en;
   logic        jpr_en;
   logic [15:0] reg_target;
   logic        branch_taken;
   logic        halt;

   int checks = 0;
   int errors = 0;

   // Reference model state: PC of the held instruction and the held word.
   logic [15:0] exp_pc;
   logic [15:0] exp_inst;

   always #5 clk = ~clk;

   instruction_fetch #(
      .WORD_SIZE (16),
      .RESET_PC  (16'h0000)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .address      (address),
      .readM        (readM),
      .data         (data),
      .inputReady   (inputReady),
      .inst         (inst),
      .inst_valid   (inst_valid),
      .pc           (pc),
      .pc_plus1     (pc_plus1),
      .commit       (commit),
      .jump_en      (jump_en),
      .jpr_en       (jpr_en),
      .reg_target   (reg_target),
      .branch_taken (branch_taken),
      .halt         (halt)
   );

   // Next PC from the architectural rules, using integer arithmetic.
   function automatic logic [15:0] ref_next(input logic [15:0] cur_pc, input logic [15:0] cur_inst,
                                            input bit jpr, input bit jmp, input bit br,
                                            input logic [15:0] tgt);
      int v;
      int off;
      if (jpr) return tgt;
      if (jmp) return (cur_pc & 16'hF000) | (cur_inst & 16'h0FFF);
      v = int'(cur_pc) + 1;
      if (br) begin
         off = int'(cur_inst & 16'h00FF);
         if (off >= 128) off = off - 256;
         v = v + off;
      end
      return 16'(v & 32'h0000FFFF);
   endfunction

   // Answer one fetch: wait for the request, answer in WAIT cycle nwait.
   // Returns the number of sampled cycles with readM high.
   task automatic serve(input logic [15:0] word, input int nwait, output int rcnt);
      int guard;
      guard = 0;
      rcnt  = 0;
      while (readM !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (readM !== 1'b1) begin
         errors++;
         $display("FAIL serve_request_timeout: readM=%b want 1", readM);
      end
      rcnt = 1;
      @(negedge clk);
      rcnt += (readM === 1'b1) ? 1 : 0;
      repeat (nwait - 1) begin
         @(negedge clk);
         rcnt += (readM === 1'b1) ? 1 : 0;
      end
      data       = word;
      inputReady = 1'b1;
      @(negedge clk);
      inputReady = 1'b0;
      data       = 16'($urandom);
      exp_inst   = word;
   endtask

   task automatic commit_pulse(input bit jpr, input bit jmp, input bit br, input bit hlt,
                               input logic [15:0] tgt);
      jpr_en       = jpr;
      jump_en      = jmp;
      branch_taken = br;
      halt         = hlt;
      reg_target   = tgt;
      commit       = 1'b1;
      exp_pc       = ref_next(exp_pc, exp_inst, jpr, jmp, br, tgt);
      @(negedge clk);
      commit       = 1'b0;
      jpr_en       = 1'b0;
      jump_en      = 1'b0;
      branch_taken = 1'b0;
      halt         = 1'b0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; data = '0; inputReady = 1'b0; commit = 1'b0;
      jump_en = 1'b0; jpr_en = 1'b0; branch_taken = 1'b0; halt = 1'b0; reg_target = '0;
      repeat (3) @(negedge clk);
      exp_pc = 16'h0000; exp_inst = 16'h0000;
      checks++; if (readM !== 1'b0) begin errors++; $display("FAIL reset_readM: got %b want 0", readM); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
      checks++; if (address !== 16'h0000) begin errors++; $display("FAIL reset_address: got %h want 0000", address); end
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want 0000", pc); end
      checks++; if (pc_plus1 !== 16'h0001) begin errors++; $display("FAIL reset_pc_plus1: got %h want 0001", pc_plus1); end
      checks++; if (inst !== 16'h0000) begin errors++; $display("FAIL reset_inst: got %h want 0000", inst); end
      $display("reset: pc=%h address=%h readM=%b", pc, address, readM);
   endtask

   task automatic test_first_fetch;
      int r;
      reset_n = 1'b1;
      @(negedge clk);
      checks++; if (readM !== 1'b1) begin errors++; $display("FAIL first_readM_rise: got %b want 1", readM); end
      serve(16'h6001, 3, r);
      checks++; if (r != 4) begin errors++; $display("FAIL first_readM_cycles: got %0d want 4", r); end
      checks++; if (readM !== 1'b0) begin errors++; $display("FAIL first_readM_drop: got %b want 0", readM); end
      checks++; if (inst !== 16'h6001) begin errors++; $display("FAIL first_inst: got %h want 6001", inst); end
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL first_inst_valid: got %b want 1", inst_valid); end
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL first_pc: got %h want 0000", pc); end
      checks++; if (pc_plus1 !== 16'h0001) begin errors++; $display("FAIL first_pc_plus1: got %h want 0001", pc_plus1); end
      $display("first fetch: inst=%h readM cycles=%0d", inst, r);
   endtask

   task automatic test_next_pc_directed;
      int r;
      commit_pulse(1, 0, 0, 0, 16'h0010);
      checks++; if (address !== 16'h0010 || readM !== 1'b1) begin errors++; $display("FAIL jpr_to_0010: address=%h readM=%b want 0010/1", address, readM); end
      serve(16'h1234, 1, r);
      commit_pulse(0, 0, 0, 0, 16'hAAAA);
      checks++; if (address !== 16'h0011) begin errors++; $display("FAIL seq_0011: got %h want 0011", address); end
      $display("sequential: next address=%h", address);
      serve(16'h0000, 1, r);
      commit_pulse(1, 0, 0, 0, 16'h5010);
      serve(16'h9ABC, 2, r);
      commit_pulse(0, 1, 0, 0, 16'h7777);
      checks++; if (address !== 16'h5ABC) begin errors++; $display("FAIL jump_5ABC: got %h want 5abc", address); end
      $display("jump: next address=%h", address);
      serve(16'h0000, 1, r);
      commit_pulse(1, 0, 0, 0, 16'h0020);
      serve(16'h00FE, 1, r);
      commit_pulse(0, 0, 1, 0, 16'h0000);
      checks++; if (address !== 16'h001F) begin errors++; $display("FAIL branch_back_001F: got %h want 001f", address); end
      $display("branch: next address=%h", address);
      serve(16'h0000, 1, r);
      commit_pulse(1, 0, 0, 0, 16'hFFFF);
      serve(16'h4321, 1, r);
      checks++; if (pc_plus1 !== 16'h0000) begin errors++; $display("FAIL pc_plus1_wrap: got %h want 0000", pc_plus1); end
      commit_pulse(0, 0, 0, 0, 16'h5555);
      checks++; if (address !== 16'h0000) begin errors++; $display("FAIL seq_wrap: got %h want 0000", address); end
      $display("wrap: next address=%h", address);
      serve(16'h0FFF, 1, r);
      commit_pulse(1, 1, 1, 0, 16'h1234);
      checks++; if (address !== 16'h1234) begin errors++; $display("FAIL jpr_priority: got %h want 1234", address); end
      $display("jpr priority: next address=%h", address);
   endtask

   task automatic test_inputready_hold;
      int r;
      serve(16'hA5A5, 1, r);
      data = 16'h5A5A;
      inputReady = 1'b1;
      @(negedge clk);
      inputReady = 1'b0;
      checks++; if (inst !== 16'hA5A5) begin errors++; $display("FAIL hold_inst_stable: got %h want a5a5", inst); end
      checks++; if (inst_valid !== 1'b1 || readM !== 1'b0) begin errors++; $display("FAIL hold_flags: inst_valid=%b readM=%b want 1/0", inst_valid, readM); end
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL hold_pc: got %h want %h", pc, exp_pc); end
      $display("inputReady in HOLD: inst=%h", inst);
      commit_pulse(0, 0, 0, 0, 16'h0000);
   endtask

   task automatic test_random;
      int r;
      int nw;
      int idle;
      logic [15:0] word;
      bit jpr, jmp, br;
      logic [15:0] tgt;
      for (int i = 0; i < 40; i++) begin
         word = 16'($urandom);
         nw   = $urandom_range(1, 4);
         serve(word, nw, r);
         checks++; if (r != nw + 1) begin errors++; $display("FAIL rand_readM_cycles[%0d]: got %0d want %0d", i, r, nw + 1); end
         // Controls toggling without commit must not disturb HOLD.
         idle = $urandom_range(0, 3);
         repeat (idle) begin
            jpr_en = ($urandom_range(0, 1) == 1);
            jump_en = ($urandom_range(0, 1) == 1);
            branch_taken = ($urandom_range(0, 1) == 1);
            reg_target = 16'($urandom);
            @(negedge clk);
         end
         checks++;
         if (inst !== word || inst_valid !== 1'b1 || pc !== exp_pc || pc_plus1 !== exp_pc + 16'd1 || readM !== 1'b0) begin
            errors++;
            $display("FAIL rand_hold[%0d]: inst=%h pc=%h pc_plus1=%h valid=%b readM=%b want %h/%h/%h/1/0",
                     i, inst, pc, pc_plus1, inst_valid, readM, word, exp_pc, exp_pc + 16'd1);
         end
         jpr = ($urandom_range(0, 3) == 0);
         jmp = ($urandom_range(0, 2) == 0);
         br  = ($urandom_range(0, 1) == 1);
         tgt = 16'($urandom);
         commit_pulse(jpr, jmp, br, 0, tgt);
         checks++;
         if (address !== exp_pc || readM !== 1'b1 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_next_pc[%0d]: address=%h readM=%b valid=%b want %h/1/0", i, address, readM, inst_valid, exp_pc);
         end
         $display("rand %0d: inst=%h jpr=%0d jmp=%0d br=%0d next=%h", i, word, jpr, jmp, br, address);
      end
   endtask

   task automatic test_halt;
      int r;
      serve(16'h00F3, 1, r);
      commit_pulse(0, 0, 1, 1, 16'h0000);
      checks++;
      if (pc !== exp_pc || readM !== 1'b0 || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL halt_entry: pc=%h readM=%b valid=%b want %h/0/0", pc, readM, inst_valid, exp_pc);
      end
      for (int i = 0; i < 20; i++) begin
         commit = ($urandom_range(0, 1) == 1);
         inputReady = ($urandom_range(0, 1) == 1);
         jpr_en = ($urandom_range(0, 1) == 1);
         reg_target = 16'($urandom);
         @(negedge clk);
         checks++;
         if (readM !== 1'b0 || inst_valid !== 1'b0 || pc !== exp_pc) begin
            errors++;
            $display("FAIL halted[%0d]: readM=%b valid=%b pc=%h want 0/0/%h", i, readM, inst_valid, pc, exp_pc);
         end
      end
      commit = 1'b0; inputReady = 1'b0; jpr_en = 1'b0;
      $display("halt: pc=%h held for 20 cycles", pc);
   endtask

   task automatic test_reset_in_wait;
      int r;
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      exp_pc = 16'h0000;
      serve(16'h1111, 1, r);
      commit_pulse(1, 0, 0, 0, 16'h4444);
      checks++; if (address !== 16'h4444) begin errors++; $display("FAIL rw_setup: got %h want 4444", address); end
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      data = 16'hDEAD;
      inputReady = 1'b1;
      #1;
      checks++;
      if (readM !== 1'b0 || inst_valid !== 1'b0 || address !== 16'h0000 || inst !== 16'h0000) begin
         errors++;
         $display("FAIL rw_async_reset: readM=%b valid=%b address=%h inst=%h want 0/0/0000/0000", readM, inst_valid, address, inst);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (readM !== 1'b1 || inst_valid !== 1'b0 || address !== 16'h0000) begin
         errors++;
         $display("FAIL rw_restart: readM=%b valid=%b address=%h want 1/0/0000", readM, inst_valid, address);
      end
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b0 || inst !== 16'h0000) begin
         errors++;
         $display("FAIL rw_late_ready_ignored: valid=%b inst=%h want 0/0000", inst_valid, inst);
      end
      data = 16'h7E57;
      @(negedge clk);
      inputReady = 1'b0;
      checks++;
      if (inst !== 16'h7E57 || inst_valid !== 1'b1 || pc !== 16'h0000) begin
         errors++;
         $display("FAIL rw_refetch: inst=%h valid=%b pc=%h want 7e57/1/0000", inst, inst_valid, pc);
      end
      $display("reset in WAIT: refetched inst=%h at pc=%h", inst, pc);
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_next_pc_directed();
      test_inputready_hold();
      test_random();
      test_halt();
      test_reset_in_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_instruction_fetch

// File: doc/instruction_fetch.md
# instruction_fetch

Multi-cycle instruction fetch stage for the 16-bit TSC CPU. It owns the PC, fetches one instruction word at a time from the shared memory port using the readM/inputReady handshake, and holds the fetched word stable on `inst` for the decode/control stage until the datapath signals commit. On commit it computes the next PC from the jump, register-jump and branch controls and starts the next fetch.

## Interface
- `WORD_SIZE`, 16, data/address width
- `RESET_PC`, 16'h0000, PC value loaded on reset
- `clk`  in  1  single clock; all state changes on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `address`  out  WORD_SIZE  memory address; equals `pc` while fetching
- `readM`  out  1  memory read request
- `data`  in  WORD_SIZE  memory read data, valid when `inputReady`=1
- `inputReady`  in  1  memory completion strobe, one cycle
- `inst`  out  WORD_SIZE  registered fetched instruction, to control/decode
- `inst_valid`  out  1  `inst` holds a fetched, uncommitted instruction
- `pc`  out  WORD_SIZE  address of `inst`
- `pc_plus1`  out  WORD_SIZE  `pc`+1 (mod 2^16), link value for JAL/JRL
- `commit`  in  1  one-cycle pulse: current instruction finished
- `jump_en`  in  1  J-type jump (JMP/JAL)
- `jpr_en`  in  1  register jump (JPR/JRL)
- `reg_target`  in  WORD_SIZE  register jump target
- `branch_taken`  in  1  evaluated branch condition is true
- `halt`  in  1  sampled with `commit`; stops fetching

## Operation
- States: IDLE, FETCH, WAIT, HOLD, HALTED.
- IDLE: entered on reset; next cycle -> FETCH.
- FETCH: `readM`=1, `address`=`pc`; next cycle -> WAIT.
- WAIT: `readM` held 1; on `inputReady`=1 capture `data` into `inst`, set `inst_valid`, -> HOLD. `readM` drops in the cycle after capture.
- HOLD: `readM`=0, `inst` stable. On `commit`: clear `inst_valid`, load next PC, -> FETCH; if `halt` also 1 -> HALTED instead (PC still updated).
- HALTED: no requests, `inst_valid`=0, until reset.
- Next-PC priority: `jpr_en` -> `reg_target`; else `jump_en` -> {`pc`[15:12], `inst`[11:0]}; else `branch_taken` -> `pc`+1+sign-extend(`inst`[7:0]); else `pc`+1.
- All PC arithmetic is WORD_SIZE-bit, wraps mod 2^16 (16'hFFFF+1 = 0; 0+1+(-2) = 16'hFFFF).
- `jump_en`, `jpr_en`, `branch_taken` are only sampled on `commit` in HOLD; ignored otherwise.
- `inputReady` outside WAIT is ignored; `commit` outside HOLD is ignored.

## Timing
- Reset (async, immediate): state IDLE, `pc`=RESET_PC, `inst`=0, `inst_valid`=0, `readM`=0, `address`=RESET_PC, `pc_plus1`=RESET_PC+1.
- Reset asserted mid-fetch drops `readM` immediately; an `inputReady` arriving during or after reset before the next WAIT is discarded.
- First `readM` rises 1 cycle after `reset_n` deassert edge (IDLE->FETCH).
- Fetch latency: `inst_valid` rises on the edge where `inputReady`=1 is sampled; minimum 2 cycles from FETCH entry when memory answers in the first WAIT cycle.
- Commit to next `readM`: 1 cycle (HOLD->FETCH on commit edge, `address` shows new PC same cycle).
- `inst`, `pc`, `pc_plus1` change only at capture/commit edges; combinationally stable during HOLD.

## Structure
- FSM state encodings and `WORD_SIZE` live in the shared opcodes include; no local redefinition.
- Sub-module `next_pc_calc`: purely combinational next-PC mux/adder (inputs `pc`, `inst`, controls, `reg_target`); FSM and registers stay in `instruction_fetch`.

## Test plan
- Reset then memory returns 16'h6001 after 3 WAIT cycles -> `readM` high 4 cycles at `address`=0, `inst`=16'h6001, `inst_valid`=1, `pc_plus1`=1.
- HOLD at `pc`=16'h0010, commit with no controls -> next `address`=16'h0011; with `jump_en`, `inst`=16'h9ABC at `pc`=16'h5010 -> 16'h5ABC.
- Branch at `pc`=16'h0020, `inst`[7:0]=8'hFE, `branch_taken` -> next PC 16'h001F; at `pc`=16'hFFFF, no controls -> 0.
- `jpr_en` and `jump_en` both high with `reg_target`=16'h1234 -> next PC 16'h1234; `inputReady` pulse in HOLD -> `inst` unchanged.
- `commit` with `halt` -> HALTED, `readM` stays 0 for 20 cycles despite further `commit` pulses.
- `reset_n` low in WAIT -> `readM`, `inst_valid` 0 before next edge; late `inputReady` ignored; fetch restarts at RESET_PC.
